uart_stim_seq: RTL and testbench

Scripted byte-stream generator that drives the AXI-stream input of the debug `uart_tx` feeding the picorv32 `uart_rx0` pin. It replaces hand-timed stimulus (soft-reset 0x14, command characters) with a programmable script of {delay, byte} entries played back on `start`. The block is synthesizable, so the same block drives both the simulation bench and on-board bring-up.

---
 rtl/uart_stim_seq.sv | 139 +++++++++++++
 tb/tb_uart_stim_seq.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_stim_seq.sv
// uart_stim_seq: plays a programmable script of {delay, byte} entries into the
// AXI-stream input of the debug uart_tx after a one-cycle start pulse.
module uart_stim_seq #(
    parameter int DEPTH   = 16,
    parameter int DELAY_W = 24,
    parameter int TIMEOUT = 1000000
) (
    input  logic                     clk_p,
    input  logic                     reset,
    input  logic                     cfg_we,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr,
    input  logic [DELAY_W+7:0]       cfg_data,
    input  logic [$clog2(DEPTH):0]   cfg_len,
    input  logic                     start,
    output logic [7:0]               m_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   sent_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [AW:0]     LEN_MAX   = (AW+1)'(DEPTH);
    localparam logic [TW-1:0]   WAIT_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_DELAY = 3'd2;
    localparam logic [2:0] S_SEND  = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    logic [DELAY_W+7:0] r_mem [DEPTH];
    logic [2:0]         r_state;
    logic [AW-1:0]      r_idx;
    logic [AW:0]        r_len;
    logic [DELAY_W-1:0] r_cnt;
    logic [TW-1:0]      r_wait;
    logic [7:0]         r_tdata;
    logic               r_tvalid;
    logic               r_err;
    logic [AW:0]        r_sent;

    logic [DELAY_W+7:0] w_entry;
    logic               w_busy;
    logic               w_last;
    logic               w_accept;
    logic               w_timeout;
    logic [AW:0]        w_len_clamped;

    assign w_entry       = r_mem[r_idx];
    assign w_busy        = (r_state != S_IDLE);
    assign w_last        = ({1'b0, r_idx} == (r_len - (AW+1)'(1)));
    assign w_accept      = r_tvalid && m_tready;
    assign w_timeout     = (TIMEOUT != 0) && (r_wait == WAIT_LAST);
    assign w_len_clamped = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;

    assign m_tdata  = r_tdata;
    assign m_tvalid = r_tvalid;
    assign busy     = w_busy;
    assign done     = (r_state == S_FIN);
    assign err      = r_err;
    assign sent_cnt = r_sent;

    // Script RAM write port: no reset so the script survives reset, locked while playing
    always_ff @(posedge clk_p) begin
        if (cfg_we && !w_busy) begin
            r_mem[cfg_addr] <= cfg_data;
        end
    end

    // Playback sequencer: load entry, count its delay, hold the byte until accepted or timed out
    always_ff @(posedge clk_p) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_wait   <= '0;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_err    <= 1'b0;
            r_sent   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx   <= '0;
                        r_len   <= w_len_clamped;
                        r_sent  <= '0;
                        r_err   <= 1'b0;
                        r_state <= (cfg_len == '0) ? S_FIN : S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_tdata <= w_entry[7:0];
                    r_cnt   <= w_entry[DELAY_W+7:8];
                    r_state <= S_DELAY;
                end
                S_DELAY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - DELAY_W'(1);
                    end else begin
                        r_tvalid <= 1'b1;
                        r_wait   <= '0;
                        r_state  <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_accept) begin
                        r_tvalid <= 1'b0;
                        r_sent   <= r_sent + (AW+1)'(1);
                        if (w_last) begin
                            r_state <= S_FIN;
                        end else begin
                            r_idx   <= r_idx + AW'(1);
                            r_state <= S_LOAD;
                        end
                    end else if (w_timeout) begin
                        r_tvalid <= 1'b0;
                        r_err    <= 1'b1;
                        r_state  <= S_FIN;
                    end else if (TIMEOUT != 0) begin
                        r_wait <= r_wait + TW'(1);
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_stim_seq.sv
// tb_uart_stim_seq: self-checking bench for uart_stim_seq; predicts beats, valid
// rise times, timeout drops and done pulses from the script it wrote.
module tb_uart_stim_seq;

    localparam int DEPTH = 16;
    localparam int DW    = 24;
    localparam int TMO   = 50;
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = AW + 1;

    typedef struct {
        int len;
        int rdy;
        int expBeats;
        int expErr;
    } vec_t;

    logic            clk_p = 1'b0;
    logic            reset;
    logic            cfg_we;
    logic [AW-1:0]   cfg_addr;
    logic [DW+7:0]   cfg_data;
    logic [LW-1:0]   cfg_len;
    logic            start;
    logic [7:0]      m_tdata;
    logic            m_tvalid;
    logic            m_tready = 1'b0;
    logic            busy;
    logic            done;
    logic            err;
    logic [LW-1:0]   sent_cnt;

    int cyc       = 0;
    int nChecks   = 0;
    int nErrors   = 0;
    int rdyMode   = 0;
    int stableErr = 0;
    int scrDelay [DEPTH];
    int scrByte  [DEPTH];
    int riseQ[$];
    int dropQ[$];
    int hsQ[$];
    int doneQ[$];
    int beatQ[$];
    logic       prevValid = 1'b0;
    logic       prevHs    = 1'b0;
    logic [7:0] prevData  = 8'h00;

    uart_stim_seq #(.DEPTH(DEPTH), .DELAY_W(DW), .TIMEOUT(TMO)) dut (
        .clk_p    (clk_p),
        .reset    (reset),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .cfg_len  (cfg_len),
        .start    (start),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .sent_cnt (sent_cnt)
    );

    // Free-running clock
    initial begin
        forever #5 clk_p = ~clk_p;
    end

    // Edge counter: value n means rising edge n has happened
    always @(posedge clk_p) begin
        cyc = cyc + 1;
    end

    // Sink ready: stuck low, stuck high, or random with 30% duty
    always @(posedge clk_p) begin
        #1;
        case (rdyMode)
            0:       m_tready = 1'b0;
            1:       m_tready = 1'b1;
            default: m_tready = ($urandom_range(0, 99) < 30);
        endcase
    end

    // Stream monitor on the falling edge: records rises, unaccepted drops, beats and done pulses
    always @(negedge clk_p) begin
        if (m_tvalid && !prevValid) riseQ.push_back(cyc);
        if (prevValid && !prevHs && m_tvalid && (m_tdata != prevData)) stableErr++;
        if (prevValid && !prevHs && !m_tvalid) dropQ.push_back(cyc);
        if (m_tvalid && m_tready) begin
            beatQ.push_back(int'(m_tdata));
            hsQ.push_back(cyc + 1);
        end
        if (done) doneQ.push_back(cyc);
        prevValid = m_tvalid;
        prevHs    = m_tvalid && m_tready;
        prevData  = m_tdata;
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic writeEntry(input int a, input int d, input int b, input bit track);
        cfg_we   = 1'b1;
        cfg_addr = a[AW-1:0];
        cfg_data = {d[DW-1:0], b[7:0]};
        @(posedge clk_p); #1;
        cfg_we = 1'b0;
        if (track) begin
            scrDelay[a] = d;
            scrByte[a]  = b;
        end
    endtask

    task automatic writeRandomScript();
        for (int a = 0; a < DEPTH; a++) begin
            writeEntry(a, int'($urandom_range(0, 5)), int'($urandom_range(0, 255)), 1'b1);
        end
    endtask

    task automatic applyStimulus(input int len, output int e0);
        riseQ.delete();
        dropQ.delete();
        hsQ.delete();
        doneQ.delete();
        beatQ.delete();
        stableErr = 0;
        cfg_len = LW'(len);
        start   = 1'b1;
        @(posedge clk_p); #1;
        e0    = cyc;
        start = 1'b0;
        checkOutput("busy_after_start", int'(busy), 1);
        checkOutput("err_cleared_by_start", int'(err), 0);
    endtask

    task automatic waitDone(input int budget);
        int k;
        k = 0;
        while (doneQ.size() == 0 && k < budget) begin
            @(posedge clk_p); #1;
            k++;
        end
        checkOutput("done_within_budget", int'(doneQ.size() > 0), 1);
        repeat (3) begin
            @(posedge clk_p); #1;
        end
    endtask

    // Reference model: beats are the first min(len,DEPTH) script bytes; each valid
    // rises 2+delay edges after start (entry 0) or after the previous acceptance.
    task automatic checkRun(input int e0, input int expBeats, input int expErr);
        int expRise;
        checkOutput("beat_count", beatQ.size(), expBeats);
        for (int k = 0; k < beatQ.size() && k < expBeats; k++) begin
            checkOutput($sformatf("beat%0d_byte", k), beatQ[k], scrByte[k]);
        end
        if (expErr == 0) begin
            checkOutput("rise_count", riseQ.size(), expBeats);
            for (int k = 0; k < riseQ.size() && k < expBeats && k <= hsQ.size(); k++) begin
                expRise = (k == 0) ? e0 + 2 + scrDelay[0] : hsQ[k-1] + 2 + scrDelay[k];
                checkOutput($sformatf("rise%0d_edge", k), riseQ[k], expRise);
            end
            checkOutput("drop_without_handshake", dropQ.size(), 0);
            checkOutput("done_count", doneQ.size(), 1);
            if (doneQ.size() > 0) begin
                if (expBeats > 0 && hsQ.size() >= expBeats) begin
                    checkOutput("done_after_last_beat", doneQ[0], hsQ[expBeats-1]);
                end else if (expBeats == 0) begin
                    checkOutput("done_after_empty_start",
                                int'(doneQ[0] >= e0 && doneQ[0] <= e0 + 1), 1);
                end
            end
        end else begin
            checkOutput("tmo_rise_count", riseQ.size(), 1);
            if (riseQ.size() > 0) checkOutput("tmo_first_rise", riseQ[0], e0 + 2 + scrDelay[0]);
            checkOutput("tmo_drop_count", dropQ.size(), 1);
            if (riseQ.size() > 0 && dropQ.size() > 0) begin
                checkOutput("tmo_drop_edge", dropQ[0], riseQ[0] + TMO);
            end
            checkOutput("done_count", doneQ.size(), 1);
            if (doneQ.size() > 0 && dropQ.size() > 0) begin
                checkOutput("tmo_done_window",
                            int'(doneQ[0] >= dropQ[0] && doneQ[0] <= dropQ[0] + 1), 1);
            end
        end
        checkOutput("err_flag", int'(err), expErr);
        checkOutput("sent_cnt", int'(sent_cnt), expBeats);
        checkOutput("busy_after_done", int'(busy), 0);
        checkOutput("tvalid_after_done", int'(m_tvalid), 0);
        checkOutput("tdata_stable_while_waiting", stableErr, 0);
    endtask

    // Global time limit so the bench always reaches an end
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence
    initial begin
        vec_t vecs [8];
        int   e0;
        int   e1;
        int   k;

        vecs[0] = '{3,  1, 3,  0};
        vecs[1] = '{1,  2, 1,  0};
        vecs[2] = '{5,  0, 0,  1};
        vecs[3] = '{4,  2, 4,  0};
        vecs[4] = '{0,  1, 0,  0};
        vecs[5] = '{16, 2, 16, 0};
        vecs[6] = '{21, 1, 16, 0};
        vecs[7] = '{31, 2, 16, 0};

        reset    = 1'b0;
        start    = 1'b0;
        cfg_we   = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        cfg_len  = '0;

        // Reset held with start/cfg_we toggling
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_p); #1;
            start    = 1'($urandom_range(0, 1));
            cfg_we   = 1'($urandom_range(0, 1));
            cfg_addr = AW'($urandom_range(0, DEPTH - 1));
            cfg_len  = LW'($urandom_range(1, DEPTH));
        end
        checkOutput("reset_tvalid", int'(m_tvalid), 0);
        checkOutput("reset_tdata", int'(m_tdata), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_err", int'(err), 0);
        checkOutput("reset_sent_cnt", int'(sent_cnt), 0);
        checkOutput("reset_no_valid_pulse", riseQ.size(), 0);
        start  = 1'b0;
        cfg_we = 1'b0;
        reset  = 1'b1;
        @(posedge clk_p); #1;

        // Soft-reset then command character with long delays
        rdyMode = 1;
        writeEntry(0, 20000, 8'h14, 1'b1);
        writeEntry(1, 40000, 8'h73, 1'b1);
        applyStimulus(2, e0);
        waitDone(70000);
        checkRun(e0, 2, 0);
        if (riseQ.size() > 0) checkOutput("first_rise_e0_plus_20002", riseQ[0], e0 + 20002);

        // Backpressure with zero delay
        rdyMode = 2;
        writeEntry(0, 0, 8'h41, 1'b1);
        writeEntry(1, 0, 8'h42, 1'b1);
        writeEntry(2, 0, 8'h43, 1'b1);
        applyStimulus(3, e0);
        waitDone(2000);
        checkRun(e0, 3, 0);

        // Vector table with randomized scripts
        for (int v = 0; v < 8; v++) begin
            rdyMode = vecs[v].rdy;
            writeRandomScript();
            applyStimulus(vecs[v].len, e0);
            waitDone(2000);
            checkRun(e0, vecs[v].expBeats, vecs[v].expErr);
        end

        // Script writes and start pulses during playback must be ignored
        rdyMode = 1;
        for (int a = 0; a < 4; a++) begin
            writeEntry(a, 20, int'($urandom_range(0, 255)), 1'b1);
        end
        applyStimulus(4, e0);
        repeat (3) begin
            @(posedge clk_p); #1;
        end
        for (int a = 0; a < 4; a++) begin
            writeEntry(a, 3, 8'hEE, 1'b0);
        end
        cfg_len = LW'(1);
        start   = 1'b1;
        @(posedge clk_p); #1;
        start = 1'b0;
        waitDone(2000);
        checkRun(e0, 4, 0);
        applyStimulus(4, e1);
        waitDone(2000);
        checkRun(e1, 4, 0);

        // Reset while a byte is waiting for acceptance, then replay
        rdyMode = 0;
        writeEntry(0, 0, 8'h5A, 1'b1);
        writeEntry(1, 0, 8'hA5, 1'b1);
        writeEntry(2, 1, 8'h3C, 1'b1);
        applyStimulus(3, e0);
        k = 0;
        while (!m_tvalid && k < 20) begin
            @(posedge clk_p); #1;
            k++;
        end
        checkOutput("mid_valid_seen", int'(m_tvalid), 1);
        repeat (3) begin
            @(posedge clk_p); #1;
        end
        doneQ.delete();
        reset = 1'b0;
        @(posedge clk_p); #1;
        checkOutput("mid_reset_tvalid", int'(m_tvalid), 0);
        checkOutput("mid_reset_busy", int'(busy), 0);
        reset = 1'b1;
        repeat (5) begin
            @(posedge clk_p); #1;
        end
        checkOutput("mid_reset_no_done", doneQ.size(), 0);
        rdyMode = 1;
        @(posedge clk_p); #1;
        applyStimulus(3, e0);
        waitDone(2000);
        checkRun(e0, 3, 0);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
